// File: rtl/mouse_event_fifo.sv
// Show-ahead mouse sample FIFO: a push at edge N is visible on the outputs after edge N; pops update the head after the edge.
// Input is never stalled (full drops new or oldest per DROP_OLD); optional MOUSE_EVENT_FIFO_COALESCE_EN merges same-button moves into the tail.
module mouse_event_fifo #(
  parameter int POS_W    = 12,
  parameter int DEPTH    = 4,
  parameter int DROP_OLD = 0
) (
  input  logic                       clk100MHz,
  input  logic                       rst_n,
  input  logic [POS_W-1:0]           xpos_in,
  input  logic [POS_W-1:0]           ypos_in,
  input  logic                       left_in,
  input  logic                       right_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [POS_W-1:0]           xpos_out,
  output logic [POS_W-1:0]           ypos_out,
  output logic                       left_out,
  output logic                       right_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  input  logic                       clr_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [POS_W-1:0] mem_x [DEPTH];
  logic [POS_W-1:0] mem_y [DEPTH];
  logic             mem_l [DEPTH];
  logic             mem_r [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_idx;
  logic push, pop, full, coalesce;
  logic wr_en, wr_adv, rd_adv, lvl_inc, ovf_set;

  assign full      = (level == LVL_W'(DEPTH));
  assign in_ready  = !full;
  assign out_valid = (level != '0);
  assign push      = in_valid;
  assign pop       = out_valid & out_ready;

  assign xpos_out  = mem_x[rd_ptr];
  assign ypos_out  = mem_y[rd_ptr];
  assign left_out  = mem_l[rd_ptr];
  assign right_out = mem_r[rd_ptr];

`ifdef MOUSE_EVENT_FIFO_COALESCE_EN
  logic [PTR_W-1:0] tail_ptr;
  assign tail_ptr = wr_ptr - PTR_W'(1);
  // The tail must never be the head being presented, so a single entry is never merged.
  assign coalesce = push
                 && (left_in == mem_l[tail_ptr]) && (right_in == mem_r[tail_ptr])
                 && ((level >= LVL_W'(2))
                     || ((level >= LVL_W'(1)) && pop && (tail_ptr != rd_ptr)));
`else
  assign coalesce = 1'b0;
`endif

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = wr_ptr;
    wr_adv  = 1'b0;
    rd_adv  = pop;
    lvl_inc = 1'b0;
    ovf_set = 1'b0;
    if (push) begin
      if (coalesce) begin
        wr_en  = 1'b1;
        wr_idx = wr_ptr - PTR_W'(1);
      end else if (!full || pop) begin
        wr_en   = 1'b1;
        wr_adv  = 1'b1;
        lvl_inc = 1'b1;
      end else if (DROP_OLD != 0) begin
        // Overwrite the oldest slot and slide the head past it; level stays at DEPTH.
        wr_en   = 1'b1;
        wr_adv  = 1'b1;
        rd_adv  = 1'b1;
        ovf_set = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_x[i] <= '0;
        mem_y[i] <= '0;
        mem_l[i] <= 1'b0;
        mem_r[i] <= 1'b0;
      end
    end else if (wr_en) begin
      mem_x[wr_idx] <= xpos_in;
      mem_y[wr_idx] <= ypos_in;
      mem_l[wr_idx] <= left_in;
      mem_r[wr_idx] <= right_in;
    end
  end

  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_adv) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_adv) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({lvl_inc, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (ovf_set)           overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mouse_event_fifo.sv
// Bench for mouse_event_fifo: a DROP_OLD=0 and a DROP_OLD=1 instance share stimulus, each checked against a queue model every cycle.
module tb_mouse_event_fifo;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        l;
    logic        r;
  } ent_t;

  logic        clk100MHz;
  logic        rst_n;
  logic [11:0] xpos_in, ypos_in;
  logic        left_in, right_in, in_valid, out_ready, clr_overflow;

  logic [11:0] o_x [2];
  logic [11:0] o_y [2];
  logic        o_l [2];
  logic        o_r [2];
  logic        o_vld [2];
  logic        o_rdy [2];
  logic        o_ovf [2];
  logic [2:0]  o_lvl [2];

  int vectors = 0;
  int miscompares = 0;

  ent_t mq [2][$];
  bit   movf [2];

  mouse_event_fifo #(.POS_W(12), .DEPTH(DEPTH), .DROP_OLD(0)) u_keep (
    .clk100MHz(clk100MHz), .rst_n(rst_n),
    .xpos_in(xpos_in), .ypos_in(ypos_in), .left_in(left_in), .right_in(right_in),
    .in_valid(in_valid), .in_ready(o_rdy[0]),
    .xpos_out(o_x[0]), .ypos_out(o_y[0]), .left_out(o_l[0]), .right_out(o_r[0]),
    .out_valid(o_vld[0]), .out_ready(out_ready),
    .level(o_lvl[0]), .overflow(o_ovf[0]), .clr_overflow(clr_overflow)
  );

  mouse_event_fifo #(.POS_W(12), .DEPTH(DEPTH), .DROP_OLD(1)) u_drop (
    .clk100MHz(clk100MHz), .rst_n(rst_n),
    .xpos_in(xpos_in), .ypos_in(ypos_in), .left_in(left_in), .right_in(right_in),
    .in_valid(in_valid), .in_ready(o_rdy[1]),
    .xpos_out(o_x[1]), .ypos_out(o_y[1]), .left_out(o_l[1]), .right_out(o_r[1]),
    .out_valid(o_vld[1]), .out_ready(out_ready),
    .level(o_lvl[1]), .overflow(o_ovf[1]), .clr_overflow(clr_overflow)
  );

  initial begin
    clk100MHz = 1'b0;
    forever #5 clk100MHz = ~clk100MHz;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue model: the FIFO as an ordered list of samples plus a sticky drop flag.
  always @(posedge clk100MHz or negedge rst_n) begin : model
    int   n;
    bit   do_pop, merge, drop;
    ent_t e;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mq[k].delete();
        movf[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        n      = mq[k].size();
        do_pop = (n > 0) && out_ready;
        merge  = 1'b0;
        drop   = 1'b0;
        e      = '{x: xpos_in, y: ypos_in, l: left_in, r: right_in};
`ifdef MOUSE_EVENT_FIFO_COALESCE_EN
        // With one entry the tail is the presented head, so merging needs two or more.
        merge = in_valid && (n >= 2) && (mq[k][n-1].l == left_in) && (mq[k][n-1].r == right_in);
`endif
        if (merge) begin
          mq[k][n-1].x = xpos_in;
          mq[k][n-1].y = ypos_in;
        end
        if (do_pop) void'(mq[k].pop_front());
        if (in_valid && !merge) begin
          if (n < DEPTH || do_pop) begin
            mq[k].push_back(e);
          end else begin
            drop = 1'b1;
            if (k == 1) begin
              void'(mq[k].pop_front());
              mq[k].push_back(e);
            end
          end
        end
        if (drop)              movf[k] = 1'b1;
        else if (clr_overflow) movf[k] = 1'b0;
      end
    end
  end

  always @(negedge clk100MHz) begin : compare
    int n;
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        n = mq[k].size();
        check($sformatf("u%0d out_valid", k), o_vld[k], n != 0);
        check($sformatf("u%0d level", k), o_lvl[k], n);
        check($sformatf("u%0d in_ready", k), o_rdy[k], n != DEPTH);
        check($sformatf("u%0d overflow", k), o_ovf[k], movf[k]);
        if (n > 0) begin
          check($sformatf("u%0d head", k), {o_x[k], o_y[k], o_l[k], o_r[k]}, mq[k][0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk100MHz);
    @(negedge clk100MHz);
  endtask

  task automatic drive(input logic v, input logic [11:0] x, input logic [11:0] y,
                       input logic l, input logic r, input logic rdy, input logic clr);
    in_valid     = v;
    xpos_in      = x;
    ypos_in      = y;
    left_in      = l;
    right_in     = r;
    out_ready    = rdy;
    clr_overflow = clr;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] last [2];
    logic [11:0] got_x [$];
    int          sent, got;
    logic [31:0] idx;

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk100MHz);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst u%0d out_valid", k), o_vld[k], 0);
      check($sformatf("rst u%0d in_ready", k), o_rdy[k], 1);
      check($sformatf("rst u%0d level", k), o_lvl[k], 0);
      check($sformatf("rst u%0d overflow", k), o_ovf[k], 0);
      check($sformatf("rst u%0d data", k), {o_x[k], o_y[k], o_l[k], o_r[k]}, 0);
    end
    rst_n = 1'b1;
    tick();

    // Single sample held while the consumer stalls.
    drive(1, 12'h010, 12'h020, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 6; c++) begin
      check("hold out_valid", o_vld[0], 1);
      check("hold level", o_lvl[0], 1);
      check("hold data", {o_x[0], o_y[0], o_l[0], o_r[0]}, {12'h010, 12'h020, 1'b1, 1'b0});
      if (c < 5) tick();
    end
    drive(0, 0, 0, 0, 0, 1, 0);
    tick();
    check("pop to empty", o_lvl[0], 0);

    // x=1..5 into a 4-deep FIFO; buttons alternate so coalescing can never apply.
    for (int i = 1; i <= 5; i++) begin
      idx = i;
      drive(1, idx[11:0], idx[11:0] + 12'h100, idx[0], 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    check("keep full level", o_lvl[0], 4);
    check("keep full in_ready", o_rdy[0], 0);
    check("keep overflow", o_ovf[0], 1);
    check("drop full level", o_lvl[1], 4);
    check("drop overflow", o_ovf[1], 1);
    drive(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      check("keep pop order", o_x[0], i + 1);
      check("drop pop order", o_x[1], i + 2);
      tick();
    end
    check("keep drained", o_vld[0], 0);
    check("drop drained", o_vld[1], 0);
    check("drop overflow before clr", o_ovf[1], 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("keep overflow cleared", o_ovf[0], 0);
    check("drop overflow cleared", o_ovf[1], 0);

    // Full FIFO with a simultaneous push and pop is not an overflow.
    for (int i = 0; i < 4; i++) begin
      idx = 10 + i;
      drive(1, idx[11:0], 0, idx[0], 0, 0, 0);
      tick();
    end
    check("refill level", o_lvl[0], 4);
    drive(1, 12'd9, 0, 0, 0, 1, 0);
    check("pre-swap head", o_x[1], 10);
    tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("swap u%0d level", k), o_lvl[k], 4);
      check($sformatf("swap u%0d overflow", k), o_ovf[k], 0);
    end
    drive(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      last[0] = o_x[0];
      last[1] = o_x[1];
      tick();
    end
    check("keep last popped", last[0], 9);
    check("drop last popped", last[1], 9);
    check("swap drained", o_vld[0], 0);

    // A drop and a clear in the same cycle leave overflow set.
    for (int i = 0; i < 4; i++) begin
      idx = 20 + i;
      drive(1, idx[11:0], 0, idx[0], 0, 0, 0);
      tick();
    end
    drive(1, 12'd24, 0, 0, 0, 0, 1);
    tick();
    check("set beats clr keep", o_ovf[0], 1);
    check("set beats clr drop", o_ovf[1], 1);
    drive(0, 0, 0, 0, 0, 1, 1);
    repeat (4) tick();
    check("clr after drain", o_ovf[0], 0);
    check("drain empty", o_vld[1], 0);

    // Streaming with a stalling consumer; producer respects in_ready so nothing is lost.
    sent = 0;
    got  = 0;
    for (int c = 0; c < 3000 && got < 100; c++) begin
      idx = sent;
      drive((sent < 100) && (mq[0].size() < DEPTH), idx[11:0], ~idx[11:0], idx[0], idx[1],
            1'($urandom_range(0, 1)), 0);
      if (o_vld[0] && out_ready) begin
        got_x.push_back(o_x[0]);
        got++;
      end
      if (in_valid) sent++;
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    check("stream count", got, 100);
    for (int i = 0; i < got_x.size(); i++) check("stream order", got_x[i], i);

`ifdef MOUSE_EVENT_FIFO_COALESCE_EN
    drive(1, 12'd1, 0, 0, 0, 0, 0); tick();
    drive(1, 12'd2, 0, 0, 0, 0, 0); tick();
    drive(1, 12'd3, 0, 0, 0, 0, 0); tick();
    drive(1, 12'd4, 0, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("coalesce level", o_lvl[0], 3);
    drive(0, 0, 0, 0, 0, 1, 0);
    check("coalesce pop0", {o_x[0], o_l[0]}, {12'd1, 1'b0}); tick();
    check("coalesce pop1", {o_x[0], o_l[0]}, {12'd3, 1'b0}); tick();
    check("coalesce pop2", {o_x[0], o_l[0]}, {12'd4, 1'b1}); tick();
    check("coalesce drained", o_vld[0], 0);
`endif

    // Reset in mid-operation empties the FIFO immediately.
    drive(1, 12'h055, 12'h066, 1, 1, 0, 0); tick();
    drive(1, 12'h077, 12'h088, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("pre-reset level", o_lvl[0], 2);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("midrst u%0d level", k), o_lvl[k], 0);
      check($sformatf("midrst u%0d out_valid", k), o_vld[k], 0);
      check($sformatf("midrst u%0d in_ready", k), o_rdy[k], 1);
      check($sformatf("midrst u%0d data", k), {o_x[k], o_y[k], o_l[k], o_r[k]}, 0);
    end
    @(negedge clk100MHz);
    #2 rst_n = 1'b1;
    tick();
    check("post-reset empty", o_vld[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mouse_event_fifo.md
Name: mouse_event_fifo

Overview:
Parametrised single-clock FIFO for mouse samples (x/y position plus left/right buttons), with valid/ready handshakes on both sides. It replaces free-running sample copying with counted, ordered buffering. Overflow handling is configurable, and a level/overflow status is exported. It sits between the mouse decoder and the game/draw control logic, inside one clock domain.

Parameters:
POS_W, 12, width of xpos/ypos fields
DEPTH, 4, number of entries; power of two, >= 2
DROP_OLD, 0, overflow policy: 0 = discard incoming sample, 1 = discard oldest entry and store incoming

Ports:
clk100MHz  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
xpos_in  input  POS_W  sample x position
ypos_in  input  POS_W  sample y position
left_in  input  1  sample left button
right_in  input  1  sample right button
in_valid  input  1  sample present this cycle
in_ready  output  1  level != DEPTH (informational; in_valid is never back-pressured)
xpos_out  output  POS_W  head entry x
ypos_out  output  POS_W  head entry y
left_out  output  1  head entry left
right_out  output  1  head entry right
out_valid  output  1  level != 0
out_ready  input  1  consumer accepts head this cycle
level  output  $clog2(DEPTH+1)  current entry count, 0..DEPTH
overflow  output  1  sticky; set when any sample is dropped
clr_overflow  input  1  synchronous clear of overflow

Behaviour:
- Reset, asynchronous on rst_n low:
  - memory, wr_ptr, rd_ptr and level go to 0; overflow goes to 0.
  - out_valid=0, in_ready=1; data outputs read 0.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. level is a separate counter.
- Output is show-ahead: data outputs are a combinational read of mem[rd_ptr].
- Write-to-out latency: a sample pushed at edge N into an empty FIFO gives out_valid=1 with that data after edge N.
- push = in_valid; pop = out_valid & out_ready.
- Normal push (level < DEPTH): mem[wr_ptr] <= inputs, wr_ptr+1, level+1.
- pop alone: rd_ptr+1, level-1.
- push & pop with 0 < level < DEPTH: write and read both happen, level unchanged.
- push & pop at level == DEPTH: both happen, level stays DEPTH, no drop, overflow unchanged.
- push at level == DEPTH with no pop:
  - DROP_OLD=0: sample discarded, state unchanged, overflow <= 1.
  - DROP_OLD=1: mem[wr_ptr] written, wr_ptr+1, rd_ptr+1, level stays DEPTH, overflow <= 1.
- push at level == 0 with out_ready=1: no pop, because out_valid is 0 that cycle.
- Handshake stability: while out_valid=1 and out_ready=0, the head data must not change. The only exception is a DROP_OLD overflow, which advances the head.
- overflow:
  - set has priority over clr_overflow in the same cycle;
  - otherwise clr_overflow clears it on the next edge.
- Reset mid-operation discards all entries immediately. No partial state survives.

Optional Feature:
Macro MOUSE_EVENT_FIFO_COALESCE_EN.
- Defined: a push coalesces when all of the following hold:
  - level >= 2, or level >= 1 with a pop in the same cycle while the tail is not the popped head;
  - buttons equal the tail entry (mem[wr_ptr-1]).
- On coalesce: the tail position is overwritten with the new x/y. wr_ptr and level are not incremented; a pop, if present, still decrements level.
- Coalescing never applies to the head entry while it is presented, so handshake stability holds.
- Button changes always create a new entry.
- A coalesce at level == DEPTH is not an overflow.
- Undefined: every push is a separate entry, as described above.

Test Plan:
- Reset, then single push x=0x010, y=0x020, left=1 with out_ready=0 -> after 1 edge: out_valid=1, level=1, outputs 0x010/0x020/1/0, held stable for 5 cycles.
- DEPTH=4, DROP_OLD=0: push x=1..5 with no pops -> level=4, in_ready=0, overflow=1; pops return x=1,2,3,4, then out_valid=0.
- DROP_OLD=1: same stimulus -> pops return x=2,3,4,5; overflow=1 until clr_overflow pulse, then 0.
- Full FIFO, push x=9 with simultaneous pop -> level stays 4, overflow stays 0, x=9 is the last entry popped.
- Continuous push+pop streaming 100 samples, with out_ready toggling pseudo-randomly -> output sequence equals input order, no loss while level < DEPTH, pointer wrap exercised.
- COALESCE_EN: push (x=1,L=0), (x=2,L=0), (x=3,L=0), (x=4,L=1) with no pops -> level=3; pops return x=1, x=3 (L=0), x=4 (L=1).
